// File: rtl/gate_test_sequencer_if.sv
// Signals between the gate-test sequencer and the gate under test.
// The master modport is the sequencer side; the slave modport is the surrounding harness.
interface gate_test_sequencer_if;
  logic       start;
  logic       dut_out;
  logic       x;
  logic       y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  modport master (
    input  start, dut_out,
    output x, y, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, dut_out,
    input  x, y, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Walks a 2-input gate through vectors 00..11, holds each for SETTLE_CYCLES, samples the gate
// output at the end of the hold and compares it with the TRUTH table.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  TRUTH         = 4'b1000
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_test_sequencer_if.master bus
);

  localparam logic [7:0] Reload = 8'(SETTLE_CYCLES);

  typedef enum logic {StIdle, StRun} state_e;

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic       x_q, x_d, y_q, y_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       mismatch;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mismatch = bus.dut_out ^ TRUTH[vec_q];

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          vec_d   = 2'd0;
          x_d     = 1'b0;
          y_d     = 1'b0;
          cnt_d   = Reload;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        cnt_d = cnt_q - 8'd1;
        // Counter at 1 marks the sample edge: score this vector, then advance or finish.
        if (cnt_q == 8'd1) begin
          if (mismatch) begin
            fail_d[vec_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          if (vec_q != 2'd3) begin
            vec_d      = vec_q + 2'd1;
            {x_d, y_d} = vec_q + 2'd1;
            cnt_d      = Reload;
          end else begin
            state_d = StIdle;
            vec_d   = 2'd0;
            x_d     = 1'b0;
            y_d     = 1'b0;
            cnt_d   = 8'd0;
            done_d  = 1'b1;
            pass_d  = (err_d == 3'd0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= 2'd0;
      cnt_q   <= 8'd0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench: three sequencers (settle 4, 2, 1) each driving a table-defined gate model.
// Stimulus pushes expected run results; a negedge monitor checks the timeline and pops results.
module tb_gate_test_sequencer;

  localparam logic [3:0] Truth = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_r;
  logic [3:0] tt_r [3];

  logic [2:0] busy_w, done_w, pass_w;
  logic [1:0] xy_w   [3];
  logic [2:0] err_w  [3];
  logic [3:0] fail_w [3];

  typedef struct packed {
    logic [1:0] g;
    logic [3:0] fail;
    logic [2:0] err;
    logic       pass;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   finish_req = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int s_of(int g);
    return (g == 0) ? 4 : (g == 1) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    gate_test_sequencer_if bus_if ();

    gate_test_sequencer #(
      .SETTLE_CYCLES((g == 0) ? 4 : (g == 1) ? 2 : 1),
      .TRUTH        (Truth)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
    );

    assign bus_if.start   = start_r[g];
    assign bus_if.dut_out = tt_r[g][{bus_if.x, bus_if.y}];
    assign busy_w[g]      = bus_if.busy;
    assign done_w[g]      = bus_if.done;
    assign pass_w[g]      = bus_if.pass;
    assign xy_w[g]        = {bus_if.x, bus_if.y};
    assign err_w[g]       = bus_if.err_count;
    assign fail_w[g]      = bus_if.fail_vec;
  end

  function automatic void chk(string name, int g, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst=%0d cycle=%0d actual=%0d expected=%0d", name, g, cyc, act, exp);
    end
  endfunction

  // Reference: score each vector of the gate table against the truth table.
  function automatic exp_t model(int g, logic [3:0] tt);
    exp_t e;
    e.g    = 2'(g);
    e.fail = 4'd0;
    e.err  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (tt[i] != Truth[i]) begin
        e.fail[i] = 1'b1;
        e.err     = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  // Monitor: owns the expected timeline (run window, done cycle, post-reset cycle).
  initial begin
    bit         in_run   [3] = '{0, 0, 0};
    bit         post_rst [3] = '{0, 0, 0};
    int         e0       [3] = '{0, 0, 0};
    logic [3:0] last_fail[3] = '{0, 0, 0};
    logic [2:0] last_err [3] = '{0, 0, 0};
    logic       last_pass[3] = '{0, 0, 0};
    int         s, t, idx;
    exp_t       e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        s = s_of(g);
        if (post_rst[g]) begin
          chk("rst_busy", g, int'(busy_w[g]), 0);
          chk("rst_done", g, int'(done_w[g]), 0);
          chk("rst_xy",   g, int'(xy_w[g]),   0);
          chk("rst_err",  g, int'(err_w[g]),  0);
          chk("rst_fail", g, int'(fail_w[g]), 0);
          chk("rst_pass", g, int'(pass_w[g]), 0);
          last_fail[g] = 4'd0;
          last_err[g]  = 3'd0;
          last_pass[g] = 1'b0;
        end else if (in_run[g]) begin
          t = cyc - e0[g];
          if (t < 4 * s) begin
            chk("run_busy", g, int'(busy_w[g]), 1);
            chk("run_done", g, int'(done_w[g]), 0);
            chk("run_xy",   g, int'(xy_w[g]),   t / s);
            chk("run_pass", g, int'(pass_w[g]), 0);
            if (t < s) begin
              chk("run_err_clr",  g, int'(err_w[g]),  0);
              chk("run_fail_clr", g, int'(fail_w[g]), 0);
            end
          end else begin
            chk("done_pulse", g, int'(done_w[g]), 1);
            chk("done_busy",  g, int'(busy_w[g]), 0);
            chk("done_xy",    g, int'(xy_w[g]),   0);
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (idx < 0 && int'(exp_q[i].g) == g) idx = i;
            end
            if (idx < 0) begin
              chk("done_expected", g, 1, 0);
            end else begin
              e = exp_q[idx];
              exp_q.delete(idx);
              chk("fail_vec",  g, int'(fail_w[g]), int'(e.fail));
              chk("err_count", g, int'(err_w[g]),  int'(e.err));
              chk("pass",      g, int'(pass_w[g]), int'(e.pass));
              last_fail[g] = e.fail;
              last_err[g]  = e.err;
              last_pass[g] = e.pass;
            end
            in_run[g] = 1'b0;
          end
        end else begin
          chk("idle_busy", g, int'(busy_w[g]), 0);
          chk("idle_done", g, int'(done_w[g]), 0);
          chk("idle_xy",   g, int'(xy_w[g]),   0);
          chk("hold_pass", g, int'(pass_w[g]), int'(last_pass[g]));
          chk("hold_err",  g, int'(err_w[g]),  int'(last_err[g]));
          chk("hold_fail", g, int'(fail_w[g]), int'(last_fail[g]));
        end
        // Inputs are stable here; decide what the next edge does.
        post_rst[g] = rst;
        if (rst) begin
          in_run[g] = 1'b0;
        end else if (!in_run[g] && start_r[g]) begin
          in_run[g] = 1'b1;
          e0[g]     = cyc + 1;
        end
      end
      if (finish_req) begin
        chk("runs_outstanding", 0, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic run(int g, logic [3:0] tt);
    tt_r[g] = tt;
    exp_q.push_back(model(g, tt));
    start_r[g] = 1'b1;
    @(posedge clk);
    #2;
    start_r[g] = 1'b0;
    repeat (4 * s_of(g) + 3) @(posedge clk);
    #2;
  endtask

  initial begin
    rst     = 1'b1;
    start_r = 3'b000;
    for (int g = 0; g < 3; g++) tt_r[g] = 4'b1000;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    run(0, 4'b1000);  // correct AND
    run(0, 4'b1110);  // OR gate under test
    run(1, 4'b1111);  // stuck at 1, settle 2
    run(2, 4'b1000);  // settle 1

    // Start held through a whole run and into the done cycle: exactly two runs.
    tt_r[0] = 4'b1000;
    exp_q.push_back(model(0, 4'b1000));
    exp_q.push_back(model(0, 4'b1000));
    start_r[0] = 1'b1;
    repeat (4 * 4 + 2) @(posedge clk);
    #2;
    start_r[0] = 1'b0;
    repeat (4 * 4 + 3) @(posedge clk);
    #2;

    // Reset at cycle 6 of a settle-4 run: no done, results discarded.
    tt_r[0]    = 4'b0110;
    start_r[0] = 1'b1;
    @(posedge clk);
    #2;
    start_r[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    run(0, 4'b1000);

    for (int n = 0; n < 12; n++) begin
      run(int'($urandom_range(0, 2)), 4'($urandom_range(0, 15)));
    end

    finish_req = 1'b1;
    repeat (5) @(posedge clk);
  end

endmodule
